// File: rtl/xor_chain_inverter_if.sv
// Valid/ready stream bundle for the XOR-chain inverter: the encoded words going in,
// the decoded words coming out, and the delivered-word count.
interface xor_chain_inverter_if #(
  parameter int IO_PAIRS = 10,
  parameter int CNT_W    = 16
);
  logic [2*IO_PAIRS-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [2*IO_PAIRS-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNT_W-1:0]      out_count;

  // master: the bench/producer side; slave: the inverter itself
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_count
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_count
  );
endinterface

// File: rtl/xor_chain_inverter.sv
// Pipelined inverse of the IO_PAIRS x DEPTH XOR/NOT network: one inverse layer per
// stage, bubble-collapsing valid/ready flow control, and a wrapping delivered-word counter.
module xor_chain_inverter #(
  parameter int IO_PAIRS = 10,
  parameter int DEPTH    = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  xor_chain_inverter_if.slave bus
);
  localparam int W = 2 * IO_PAIRS;

  // Undoes one forward layer per pair: o1 = i1 ^ i0, o0 = ~i0
  function automatic logic [W-1:0] invLayer(input logic [W-1:0] enc);
    logic [W-1:0] dec;
    dec = '0;
    for (int j = 0; j < IO_PAIRS; j++) begin
      dec[2*j]   = ~enc[2*j];
      dec[2*j+1] = ~(enc[2*j+1] ^ enc[2*j]);
    end
    return dec;
  endfunction

  logic [W-1:0]     stgData [DEPTH];
  logic [W-1:0]     srcData [DEPTH];
  logic [DEPTH-1:0] stgValid;
  logic [DEPTH-1:0] upValid;
  logic [DEPTH-1:0] moveStg;
  logic [DEPTH-1:0] leaveStg;
  logic [CNT_W-1:0] outCount;
  logic             outFire;

  always_comb begin
    upValid    = '0;
    srcData[0] = bus.in_data;
    upValid[0] = bus.in_valid;
    for (int k = 1; k < DEPTH; k++) begin
      srcData[k] = stgData[k-1];
      upValid[k] = stgValid[k-1];
    end
  end

  // Walk from the output back so each stage sees whether its own word is leaving
  always_comb begin
    outFire  = stgValid[DEPTH-1] & bus.out_ready;
    moveStg  = '0;
    leaveStg = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (k == DEPTH - 1) leaveStg[k] = outFire;
      else                leaveStg[k] = moveStg[k+1];
      moveStg[k] = upValid[k] & (~stgValid[k] | leaveStg[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stgValid <= '0;
      outCount <= '0;
      for (int k = 0; k < DEPTH; k++) stgData[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (moveStg[k]) begin
          stgData[k]  <= invLayer(srcData[k]);
          stgValid[k] <= 1'b1;
        end else if (leaveStg[k]) begin
          stgValid[k] <= 1'b0;
        end
      end
      if (outFire) outCount <= outCount + 1'b1;
    end
  end

  assign bus.in_ready  = ~stgValid[0] | leaveStg[0];
  assign bus.out_data  = stgData[DEPTH-1];
  assign bus.out_valid = stgValid[DEPTH-1];
  assign bus.out_count = outCount;
endmodule
